// File: rtl/or1k_wb_ram_slave_if.sv
// Wishbone B3 bus bundle between an OR1K iwb/dwb master and the on-chip RAM slave.
// Carries the classic handshake plus the cti/bte burst tags.
interface or1k_wb_ram_slave_if;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/or1k_wb_ram_slave.sv
// Wishbone B3 registered-feedback RAM slave: classic cycles plus linear/wrapping
// bursts at one beat per clock, optional wait states, error on out-of-window access.
module or1k_wb_ram_slave #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    or1k_wb_ram_slave_if.slave wb
);
    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH   = 1 << WORD_AW;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SINGLE = 3'd2;
    localparam logic [2:0] ST_BURST  = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    logic [31:0]        mem [DEPTH];
    logic [2:0]         state_q;
    logic [WORD_AW-1:0] beat_q;
    logic [3:0]         wait_q;
    logic [31:0]        dat_q;
    logic               ack_q;
    logic               err_q;

    logic               req;
    logic               in_range;
    logic               mem_we;
    logic [WORD_AW-1:0] req_word;
    logic [WORD_AW-1:0] wrap_mask;
    logic [WORD_AW-1:0] next_word;
    logic               unused_adr_bits;

    assign req             = wb.cyc & wb.stb;
    assign in_range        = (wb.adr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign req_word        = wb.adr[ADDR_WIDTH-1:2];
    assign unused_adr_bits = ^wb.adr[1:0];

    // Wrapping bursts only advance the low word-address bits; the rest stay put.
    always_comb begin
        wrap_mask = '1;
        case (wb.bte)
            2'b01:   wrap_mask = WORD_AW'(3);
            2'b10:   wrap_mask = WORD_AW'(7);
            2'b11:   wrap_mask = WORD_AW'(15);
            default: wrap_mask = '1;
        endcase
        next_word = (beat_q & ~wrap_mask) | ((beat_q + WORD_AW'(1)) & wrap_mask);
    end

    // A write commits on the edge where ack is showing and the master still strobes.
    assign mem_we = req & wb.we & ((state_q == ST_SINGLE) | (state_q == ST_BURST));

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wb.sel[i]) begin
                    mem[beat_q][8*i +: 8] <= wb.dat_w[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (!in_range) begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end else begin
                            beat_q <= req_word;
                            if (WAIT_STATES == 0) begin
                                ack_q   <= 1'b1;
                                dat_q   <= mem[req_word];
                                state_q <= (wb.cti == CTI_INCR) ? ST_BURST : ST_SINGLE;
                            end else begin
                                wait_q  <= 4'(WAIT_STATES - 1);
                                state_q <= ST_WAIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_q <= ST_IDLE;
                    end else if (wait_q == 4'd0) begin
                        ack_q   <= 1'b1;
                        dat_q   <= mem[beat_q];
                        state_q <= (wb.cti == CTI_INCR) ? ST_BURST : ST_SINGLE;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ST_SINGLE: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                // Past the first beat the internal counter drives the address.
                ST_BURST: begin
                    if (!req || wb.cti == CTI_END) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        beat_q <= next_word;
                        dat_q  <= mem[next_word];
                    end
                end
                ST_ERR: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wb.dat_r = dat_q;
    assign wb.ack   = ack_q;
    assign wb.err   = err_q;
    assign wb.rty   = 1'b0;
endmodule
